// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with latency-matched sync and blank outputs
module vga_timing_gen #(
    parameter int CW      = 10,
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYN    = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 11,
    parameter int VSYN    = 2,
    parameter int VBP     = 32,
    parameter bit HPOL    = 1'b0,
    parameter bit VPOL    = 1'b0,
    parameter int LAT     = 2,
    parameter int FCW     = 8
) (
    input  logic           vgaclk,
    input  logic           reset_n,
    input  logic           ce,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           active,
    output logic           hsync,
    output logic           vsync,
    output logic           sync_b,
    output logic           blank_b,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);
    localparam int HMAX = HACTIVE + HFP + HSYN + HBP;
    localparam int VMAX = VACTIVE + VFP + VSYN + VBP;
    localparam logic [CW-1:0] XLAST = CW'(HMAX - 1);
    localparam logic [CW-1:0] YLAST = CW'(VMAX - 1);
    localparam logic [CW-1:0] XACT  = CW'(HACTIVE);
    localparam logic [CW-1:0] YACT  = CW'(VACTIVE);
    localparam logic [CW-1:0] HS0   = CW'(HACTIVE + HFP);
    localparam logic [CW-1:0] HS1   = CW'(HACTIVE + HFP + HSYN);
    localparam logic [CW-1:0] VS0   = CW'(VACTIVE + VFP);
    localparam logic [CW-1:0] VS1   = CW'(VACTIVE + VFP + VSYN);
    // idle levels in {hsync, vsync, sync_b, blank_b} order
    localparam logic [3:0] IDLE = {~HPOL, ~VPOL, 1'b1, 1'b0};

    logic       hs_raw;
    logic       vs_raw;
    logic [3:0] raw;
    logic [3:0] dly;

    // pixel, line and frame counters advance on each enabled pixel
    always_ff @(posedge vgaclk) begin
        if (!reset_n) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
        end else if (ce) begin
            x <= (x == XLAST) ? '0 : x + CW'(1);
            if (x == XLAST) begin
                y <= (y == YLAST) ? '0 : y + CW'(1);
                if (y == YLAST) frame_cnt <= frame_cnt + FCW'(1);
            end
        end
    end

    // undelayed decodes of the current counter position
    always_comb begin
        hs_raw      = (x >= HS0) && (x < HS1);
        vs_raw      = (y >= VS0) && (y < VS1);
        active      = (x < XACT) && (y < YACT);
        raw         = {hs_raw ? HPOL : ~HPOL, vs_raw ? VPOL : ~VPOL, ~(hs_raw | vs_raw), active};
        line_start  = reset_n && ce && (x == '0);
        frame_start = line_start && (y == '0);
    end

    generate
        if (LAT == 0) begin : g_nodly
            assign dly = raw;
        end else begin : g_dly
            logic [3:0] sr [LAT];
            // shift register aligning sync/blank with the downstream pixel pipeline
            always_ff @(posedge vgaclk) begin
                if (!reset_n) begin
                    for (int i = 0; i < LAT; i++) sr[i] <= IDLE;
                end else if (ce) begin
                    sr[0] <= raw;
                    for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
                end
            end
            assign dly = sr[LAT-1];
        end
    endgenerate

    assign {hsync, vsync, sync_b, blank_b} = dly;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized check of three timing generator configurations against a closed-form model
module tb_vga_timing_gen;
    typedef struct packed {
        int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, lat, fcw;
    } cfg_t;
    typedef struct {
        int x, y, act, hs, vs, sb, bb, ls, fs, fc;
    } exp_t;

    localparam cfg_t CA = '{8, 1, 2, 1, 4, 1, 1, 1, 0, 0, 2, 2};
    localparam cfg_t CB = '{20, 3, 4, 5, 10, 2, 3, 2, 1, 1, 0, 3};
    localparam cfg_t CC = '{640, 16, 96, 48, 480, 11, 2, 32, 0, 0, 2, 8};

    logic vgaclk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b1;
    int   e = 0;
    bit   started = 1'b0;
    bit   pin_rst = 1'b0;
    bit   pin_13 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] xa, ya;
    logic [1:0] fca;
    logic       acta, hsa, vsa, sba, bba, lsa, fsa;
    logic [5:0] xb, yb;
    logic [2:0] fcb;
    logic       actb, hsb, vsb, sbb, bbb, lsb, fsb;
    logic [9:0] xc, yc;
    logic [7:0] fcc;
    logic       actc, hsc, vsc, sbc, bbc, lsc, fsc;

    vga_timing_gen #(.CW(4), .HACTIVE(CA.ha), .HFP(CA.hf), .HSYN(CA.hs), .HBP(CA.hb),
                     .VACTIVE(CA.va), .VFP(CA.vf), .VSYN(CA.vs), .VBP(CA.vb),
                     .HPOL(1'(CA.hp)), .VPOL(1'(CA.vp)), .LAT(CA.lat), .FCW(2)) dut_a (
        .vgaclk(vgaclk), .reset_n(reset_n), .ce(ce), .x(xa), .y(ya), .active(acta),
        .hsync(hsa), .vsync(vsa), .sync_b(sba), .blank_b(bba), .line_start(lsa),
        .frame_start(fsa), .frame_cnt(fca));

    vga_timing_gen #(.CW(6), .HACTIVE(CB.ha), .HFP(CB.hf), .HSYN(CB.hs), .HBP(CB.hb),
                     .VACTIVE(CB.va), .VFP(CB.vf), .VSYN(CB.vs), .VBP(CB.vb),
                     .HPOL(1'(CB.hp)), .VPOL(1'(CB.vp)), .LAT(CB.lat), .FCW(3)) dut_b (
        .vgaclk(vgaclk), .reset_n(reset_n), .ce(ce), .x(xb), .y(yb), .active(actb),
        .hsync(hsb), .vsync(vsb), .sync_b(sbb), .blank_b(bbb), .line_start(lsb),
        .frame_start(fsb), .frame_cnt(fcb));

    vga_timing_gen dut_c (
        .vgaclk(vgaclk), .reset_n(reset_n), .ce(ce), .x(xc), .y(yc), .active(actc),
        .hsync(hsc), .vsync(vsc), .sync_b(sbc), .blank_b(bbc), .line_start(lsc),
        .frame_start(fsc), .frame_cnt(fcc));

    always #5 vgaclk = ~vgaclk;

    // expected outputs after e enabled pixels since reset, derived directly from the raster rules
    function automatic exp_t model(cfg_t c, int n, bit cen, bit rn);
        exp_t m;
        int hm, vm, k, kx, ky;
        bit h, v;
        hm = c.ha + c.hf + c.hs + c.hb;
        vm = c.va + c.vf + c.vs + c.vb;
        m.x = n % hm;
        m.y = (n / hm) % vm;
        m.fc = (n / (hm * vm)) % (1 << c.fcw);
        m.act = int'(m.x < c.ha && m.y < c.va);
        m.ls = int'(rn && cen && m.x == 0);
        m.fs = int'(m.ls == 1 && m.y == 0);
        if (n < c.lat) begin
            m.hs = 1 - c.hp;
            m.vs = 1 - c.vp;
            m.sb = 1;
            m.bb = 0;
        end else begin
            k  = n - c.lat;
            kx = k % hm;
            ky = (k / hm) % vm;
            h  = kx >= c.ha + c.hf && kx < c.ha + c.hf + c.hs;
            v  = ky >= c.va + c.vf && ky < c.va + c.vf + c.vs;
            m.hs = h ? c.hp : 1 - c.hp;
            m.vs = v ? c.vp : 1 - c.vp;
            m.sb = int'(!(h || v));
            m.bb = int'(kx < c.ha && ky < c.va);
        end
        return m;
    endfunction

    task automatic cmp(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t e=%0d: got %0d expected %0d", n, $time, e, act, exp);
        end
    endtask

    task automatic check_all(string t, exp_t m, int x, int y, int act, int hs, int vs,
                             int sb, int bb, int ls, int fs, int fc);
        cmp({t, ".x"}, x, m.x);
        cmp({t, ".y"}, y, m.y);
        cmp({t, ".active"}, act, m.act);
        cmp({t, ".hsync"}, hs, m.hs);
        cmp({t, ".vsync"}, vs, m.vs);
        cmp({t, ".sync_b"}, sb, m.sb);
        cmp({t, ".blank_b"}, bb, m.bb);
        cmp({t, ".line_start"}, ls, m.ls);
        cmp({t, ".frame_start"}, fs, m.fs);
        cmp({t, ".frame_cnt"}, fc, m.fc);
    endtask

    // model position: count enabled pixels since the last reset edge
    always @(posedge vgaclk) begin
        if (!reset_n) begin
            e <= 0;
            started <= 1'b1;
        end else if (ce) begin
            e <= e + 1;
        end
    end

    // compare every instance against the model midway between active edges
    always @(negedge vgaclk) begin
        if (started) begin
            check_all("A", model(CA, e, ce, reset_n), int'(xa), int'(ya), int'(acta), int'(hsa),
                      int'(vsa), int'(sba), int'(bba), int'(lsa), int'(fsa), int'(fca));
            check_all("B", model(CB, e, ce, reset_n), int'(xb), int'(yb), int'(actb), int'(hsb),
                      int'(vsb), int'(sbb), int'(bbb), int'(lsb), int'(fsb), int'(fcb));
            check_all("C", model(CC, e, ce, reset_n), int'(xc), int'(yc), int'(actc), int'(hsc),
                      int'(vsc), int'(sbc), int'(bbc), int'(lsc), int'(fsc), int'(fcc));
            if (!reset_n && !pin_rst) begin
                pin_rst <= 1'b1;
                cmp("rst.A.x", int'(xa), 0);
                cmp("rst.A.frame_cnt", int'(fca), 0);
                cmp("rst.A.hsync", int'(hsa), 1);
                cmp("rst.A.blank_b", int'(bba), 0);
                cmp("rst.A.line_start", int'(lsa), 0);
                cmp("rst.B.hsync", int'(hsb), 0);
                cmp("rst.C.active", int'(actc), 1);
            end
            if (reset_n && e == 13 && !pin_13) begin
                pin_13 <= 1'b1;
                cmp("e13.A.x", int'(xa), 1);
                cmp("e13.A.y", int'(ya), 1);
                cmp("e13.A.blank_b", int'(bba), 0);
                cmp("e13.C.x", int'(xc), 13);
                cmp("e13.C.blank_b", int'(bbc), 1);
            end
        end
    end

    task automatic tick(bit r, bit c);
        @(posedge vgaclk);
        #1;
        reset_n = r;
        ce = c;
    endtask

    initial begin
        exp_t m;
        m = model(CC, 800, 1'b1, 1'b1);
        cmp("model.C.x@800", m.x, 0);
        cmp("model.C.y@800", m.y, 1);
        cmp("model.C.ls@800", m.ls, 1);
        m = model(CC, 657, 1'b1, 1'b1);
        cmp("model.C.hs@657", m.hs, 1);
        m = model(CC, 658, 1'b1, 1'b1);
        cmp("model.C.hs@658", m.hs, 0);
        m = model(CC, 753, 1'b1, 1'b1);
        cmp("model.C.hs@753", m.hs, 0);
        m = model(CC, 754, 1'b1, 1'b1);
        cmp("model.C.hs@754", m.hs, 1);
        m = model(CA, 84, 1'b1, 1'b1);
        cmp("model.A.fc@84", m.fc, 1);
        m = model(CA, 335, 1'b1, 1'b1);
        cmp("model.A.fc@335", m.fc, 3);
        m = model(CA, 336, 1'b1, 1'b1);
        cmp("model.A.fc@336", m.fc, 0);
        m = model(CA, 1, 1'b1, 1'b1);
        cmp("model.A.bb@1", m.bb, 0);
        m = model(CB, 384, 1'b1, 1'b1);
        cmp("model.B.vs@384", m.vs, 1);
        cmp("model.B.sb@384", m.sb, 0);

        tick(1'b0, 1'b1);
        repeat (1200) tick(1'b1, 1'b1);
        for (int i = 0; i < 200; i++) tick(1'b1, i[0] == 1'b0);
        tick(1'b0, 1'b1);
        repeat (600) tick(1'b1, 1'b1);
        repeat (25000) tick($urandom_range(0, 999) != 0, $urandom_range(0, 3) != 0);
        tick(1'b1, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
